// File: rtl/hazard_pipe_tracker_if.sv
// Hazard-tracker bundle: D-stage instruction metadata in, E/M/W hazard state, stall and stall count out.
// master = decode/forwarding side driving D fields; slave = the tracker itself.
interface hazard_pipe_tracker_if #(
   parameter int REG_AW = 5,
   parameter int TNEW_W = 2
);
   logic [REG_AW-1:0] a1_D;
   logic [REG_AW-1:0] a2_D;
   logic [REG_AW-1:0] a3_D;
   logic              regwrite_D;
   logic [TNEW_W-1:0] tnew_D;
   logic [TNEW_W-1:0] tuse_rs_D;
   logic [TNEW_W-1:0] tuse_rt_D;
   logic [2:0]        grfwdm_sel_D;
   logic              flush_E;

   logic              stall;
   logic [REG_AW-1:0] a1_E;
   logic [REG_AW-1:0] a2_E;
   logic [REG_AW-1:0] a3_E;
   logic [REG_AW-1:0] a2_M;
   logic [REG_AW-1:0] a3_M;
   logic [REG_AW-1:0] a3_W;
   logic [TNEW_W-1:0] tnew_E;
   logic [TNEW_W-1:0] tnew_M;
   logic              regwrite_E;
   logic              regwrite_M;
   logic              regwrite_W;
   logic [2:0]        grfwdm_sel_M;
   logic [31:0]       stall_cnt;

   modport master (
      output a1_D, a2_D, a3_D, regwrite_D, tnew_D, tuse_rs_D, tuse_rt_D, grfwdm_sel_D, flush_E,
      input  stall, a1_E, a2_E, a3_E, a2_M, a3_M, a3_W, tnew_E, tnew_M,
             regwrite_E, regwrite_M, regwrite_W, grfwdm_sel_M, stall_cnt
   );

   modport slave (
      input  a1_D, a2_D, a3_D, regwrite_D, tnew_D, tuse_rs_D, tuse_rt_D, grfwdm_sel_D, flush_E,
      output stall, a1_E, a2_E, a3_E, a2_M, a3_M, a3_W, tnew_E, tnew_M,
             regwrite_E, regwrite_M, regwrite_W, grfwdm_sel_M, stall_cnt
   );
endinterface

// File: rtl/hazard_pipe_tracker.sv
// Carries hazard metadata D->E->M->W (1/2/3 cycle latency) and raises a combinational D-stage stall.
// Stall bubbles E while M/W always advance; optional stall counter under HAZARD_STATS_EN.
module hazard_pipe_tracker #(
   parameter int REG_AW = 5,
   parameter int TNEW_W = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   hazard_pipe_tracker_if.slave hp
);
   localparam logic [TNEW_W-1:0] TUSE_NONE = '1;

   logic [REG_AW-1:0] a1_e_q, a1_e_d, a2_e_q, a2_e_d, a3_e_q, a3_e_d;
   logic [REG_AW-1:0] a2_m_q, a2_m_d, a3_m_q, a3_m_d, a3_w_q, a3_w_d;
   logic [TNEW_W-1:0] tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;
   logic              regwrite_e_q, regwrite_e_d, regwrite_m_q, regwrite_m_d;
   logic              regwrite_w_q, regwrite_w_d;
   logic [2:0]        sel_e_q, sel_e_d, sel_m_q, sel_m_d;
   logic              stall;

   // A source hazards only if its producer still needs more cycles than the consumer can wait.
   function automatic logic src_hit(input logic [REG_AW-1:0] a, input logic [TNEW_W-1:0] tuse);
      logic hit_e, hit_m;
      hit_e = (a == a3_e_q) && regwrite_e_q && (tuse < tnew_e_q);
      hit_m = (a == a3_m_q) && regwrite_m_q && (tuse < tnew_m_q);
      return (a != '0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
   endfunction

   always_comb begin
      stall = src_hit(hp.a1_D, hp.tuse_rs_D) | src_hit(hp.a2_D, hp.tuse_rt_D);
   end

   always_comb begin
      a1_e_d       = hp.a1_D;
      a2_e_d       = hp.a2_D;
      a3_e_d       = hp.a3_D;
      regwrite_e_d = hp.regwrite_D;
      tnew_e_d     = hp.tnew_D;
      sel_e_d      = hp.grfwdm_sel_D;
      if (stall || hp.flush_E) begin
         a1_e_d       = '0;
         a2_e_d       = '0;
         a3_e_d       = '0;
         regwrite_e_d = 1'b0;
         tnew_e_d     = '0;
         sel_e_d      = '0;
      end
      a2_m_d       = a2_e_q;
      a3_m_d       = a3_e_q;
      regwrite_m_d = regwrite_e_q;
      sel_m_d      = sel_e_q;
      tnew_m_d     = (tnew_e_q == '0) ? '0 : tnew_e_q - 1'b1;
      a3_w_d       = a3_m_q;
      regwrite_w_d = regwrite_m_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a1_e_q       <= '0;
         a2_e_q       <= '0;
         a3_e_q       <= '0;
         regwrite_e_q <= 1'b0;
         tnew_e_q     <= '0;
         sel_e_q      <= '0;
         a2_m_q       <= '0;
         a3_m_q       <= '0;
         regwrite_m_q <= 1'b0;
         tnew_m_q     <= '0;
         sel_m_q      <= '0;
         a3_w_q       <= '0;
         regwrite_w_q <= 1'b0;
      end else begin
         a1_e_q       <= a1_e_d;
         a2_e_q       <= a2_e_d;
         a3_e_q       <= a3_e_d;
         regwrite_e_q <= regwrite_e_d;
         tnew_e_q     <= tnew_e_d;
         sel_e_q      <= sel_e_d;
         a2_m_q       <= a2_m_d;
         a3_m_q       <= a3_m_d;
         regwrite_m_q <= regwrite_m_d;
         tnew_m_q     <= tnew_m_d;
         sel_m_q      <= sel_m_d;
         a3_w_q       <= a3_w_d;
         regwrite_w_q <= regwrite_w_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'h0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hp.stall_cnt = stall_cnt_q;
`else
   assign hp.stall_cnt = 32'h0;
`endif

   assign hp.stall        = stall;
   assign hp.a1_E         = a1_e_q;
   assign hp.a2_E         = a2_e_q;
   assign hp.a3_E         = a3_e_q;
   assign hp.regwrite_E   = regwrite_e_q;
   assign hp.tnew_E       = tnew_e_q;
   assign hp.a2_M         = a2_m_q;
   assign hp.a3_M         = a3_m_q;
   assign hp.regwrite_M   = regwrite_m_q;
   assign hp.tnew_M       = tnew_m_q;
   assign hp.grfwdm_sel_M = sel_m_q;
   assign hp.a3_W         = a3_w_q;
   assign hp.regwrite_W   = regwrite_w_q;
endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Bench for hazard_pipe_tracker: directed load-use/flush/reset sequences then random traffic,
// checked against a timeline model of when each in-flight instruction's result becomes available.
module tb_hazard_pipe_tracker;
   typedef struct packed {
      logic [4:0] a1;
      logic [4:0] a2;
      logic [4:0] a3;
      logic       rw;
      logic [1:0] tnew;
      logic [2:0] sel;
   } ent_t;

   localparam ent_t BUBBLE = '0;

   logic clk = 1'b0;
   logic reset;
   hazard_pipe_tracker_if #(.REG_AW(5), .TNEW_W(2)) hp_if ();

   hazard_pipe_tracker #(.REG_AW(5), .TNEW_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .hp    (hp_if)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   ent_t        hist [0:4095];   // hist[c] = instruction occupying E during cycle c
   int          cyc;
   logic [31:0] cnt_model;
   logic        last_stall;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Consumer must wait if the producer (age cycles past E entry) finishes later than consumer needs it.
   function automatic logic model_hit(input logic [4:0] a, input logic [1:0] tuse);
      for (int age = 0; age < 2; age++) begin
         ent_t p;
         int   remaining;
         p = hist[cyc - age];
         remaining = int'(p.tnew) - age;
         if (a != 0 && tuse != 2'd3 && p.rw && p.a3 == a && int'(tuse) < remaining) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic step(input ent_t d, input logic [1:0] ur, input logic [1:0] ut,
                       input logic fl, input logic rs);
      ent_t        e, m, w;
      logic        exp_stall;
      logic [1:0]  exp_tnew_m;
      hp_if.a1_D = d.a1;
      hp_if.a2_D = d.a2;
      hp_if.a3_D = d.a3;
      hp_if.regwrite_D = d.rw;
      hp_if.tnew_D = d.tnew;
      hp_if.grfwdm_sel_D = d.sel;
      hp_if.tuse_rs_D = ur;
      hp_if.tuse_rt_D = ut;
      hp_if.flush_E = fl;
      reset = rs;
      #2;
      e = hist[cyc];
      m = hist[cyc - 1];
      w = hist[cyc - 2];
      exp_stall = model_hit(d.a1, ur) | model_hit(d.a2, ut);
      exp_tnew_m = (m.tnew > 0) ? m.tnew - 2'd1 : 2'd0;
      check_val("stall", 32'(hp_if.stall), 32'(exp_stall));
      check_val("a1_E", 32'(hp_if.a1_E), 32'(e.a1));
      check_val("a2_E", 32'(hp_if.a2_E), 32'(e.a2));
      check_val("a3_E", 32'(hp_if.a3_E), 32'(e.a3));
      check_val("regwrite_E", 32'(hp_if.regwrite_E), 32'(e.rw));
      check_val("tnew_E", 32'(hp_if.tnew_E), 32'(e.tnew));
      check_val("a2_M", 32'(hp_if.a2_M), 32'(m.a2));
      check_val("a3_M", 32'(hp_if.a3_M), 32'(m.a3));
      check_val("regwrite_M", 32'(hp_if.regwrite_M), 32'(m.rw));
      check_val("tnew_M", 32'(hp_if.tnew_M), 32'(exp_tnew_m));
      check_val("grfwdm_sel_M", 32'(hp_if.grfwdm_sel_M), 32'(m.sel));
      check_val("a3_W", 32'(hp_if.a3_W), 32'(w.a3));
      check_val("regwrite_W", 32'(hp_if.regwrite_W), 32'(w.rw));
      check_val("stall_cnt", hp_if.stall_cnt, cnt_model);
      last_stall = exp_stall;
      if (rs) begin
         hist[cyc + 1] = BUBBLE;
         hist[cyc]     = BUBBLE;
         hist[cyc - 1] = BUBBLE;
      end else begin
         hist[cyc + 1] = (exp_stall || fl) ? BUBBLE : d;
      end
`ifdef HAZARD_STATS_EN
      if (rs) cnt_model = 32'h0;
      else if (exp_stall && cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 32'd1;
`endif
      cyc++;
      @(posedge clk);
      #1;
   endtask

   function automatic ent_t mk(input int a1, input int a2, input int a3, input int rw,
                               input int tnew, input int sel);
      ent_t r;
      r.a1 = a1[4:0];
      r.a2 = a2[4:0];
      r.a3 = a3[4:0];
      r.rw = rw[0];
      r.tnew = tnew[1:0];
      r.sel = sel[2:0];
      return r;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(BUBBLE, 2'd3, 2'd3, 1'b0, 1'b0);
   endtask

   initial begin
      ent_t lw3, d;
      logic [1:0] ur, ut;
      logic fl, rs;
      for (int i = 0; i < 4096; i++) hist[i] = BUBBLE;
      cyc = 2;
      cnt_model = 32'h0;
      last_stall = 1'b0;
      reset = 1'b1;
      hp_if.a1_D = '0; hp_if.a2_D = '0; hp_if.a3_D = '0;
      hp_if.regwrite_D = 1'b0; hp_if.tnew_D = '0; hp_if.grfwdm_sel_D = '0;
      hp_if.tuse_rs_D = 2'd3; hp_if.tuse_rt_D = 2'd3; hp_if.flush_E = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      lw3 = mk(0, 0, 3, 1, 2, 5);

      // load then use with tuse=1: one stall, consumer held in D
      step(lw3, 2'd3, 2'd3, 1'b0, 1'b0);
      step(mk(3, 0, 4, 1, 1, 1), 2'd1, 2'd3, 1'b0, 1'b0);
      check_val("s1_stall_first", 32'(last_stall), 32'd1);
      step(mk(3, 0, 4, 1, 1, 1), 2'd1, 2'd3, 1'b0, 1'b0);
      check_val("s1_stall_released", 32'(last_stall), 32'd0);
      idle(3);

      // load then branch with tuse=0: two stalls
      step(lw3, 2'd3, 2'd3, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(mk(3, 0, 0, 0, 0, 0), 2'd0, 2'd3, 1'b0, 1'b0);
      idle(3);
`ifdef HAZARD_STATS_EN
      check_val("s12_stall_cnt", hp_if.stall_cnt, 32'd3);
`endif

      // writes to $0 never stall
      step(mk(0, 0, 0, 1, 2, 2), 2'd3, 2'd3, 1'b0, 1'b0);
      step(mk(0, 0, 0, 0, 0, 0), 2'd0, 2'd0, 1'b0, 1'b0);
      check_val("s3_zero_dest", 32'(last_stall), 32'd0);
      idle(2);

      // flush bubbles a valid D instruction while older ones drain
      step(mk(0, 0, 7, 1, 1, 3), 2'd3, 2'd3, 1'b0, 1'b0);
      step(mk(0, 0, 6, 1, 0, 4), 2'd3, 2'd3, 1'b0, 1'b0);
      step(mk(0, 0, 5, 1, 1, 2), 2'd3, 2'd3, 1'b1, 1'b0);
      step(mk(0, 0, 5, 1, 1, 2), 2'd3, 2'd3, 1'b0, 1'b0);
      idle(3);

      // reset in the middle of a load-use stall
      step(lw3, 2'd3, 2'd3, 1'b0, 1'b0);
      step(mk(3, 0, 0, 0, 0, 0), 2'd0, 2'd3, 1'b0, 1'b0);
      step(mk(3, 0, 0, 0, 0, 0), 2'd0, 2'd3, 1'b0, 1'b1);
      step(mk(3, 0, 0, 0, 0, 0), 2'd0, 2'd3, 1'b0, 1'b0);
      check_val("s5_stall_after_reset", 32'(last_stall), 32'd0);
      idle(3);

`ifdef HAZARD_STATS_EN
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      cnt_model = 32'hFFFF_FFFE;
      step(lw3, 2'd3, 2'd3, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(mk(3, 0, 0, 0, 0, 0), 2'd0, 2'd3, 1'b0, 1'b0);
      check_val("cnt_saturated", hp_if.stall_cnt, 32'hFFFF_FFFF);
      idle(2);
`endif

      // random traffic on a small register set so hazards are frequent; stalled D is held
      d = BUBBLE;
      ur = 2'd3;
      ut = 2'd3;
      for (int i = 0; i < 2000; i++) begin
         if (!last_stall) begin
            d.a1 = 5'($urandom_range(0, 3));
            d.a2 = 5'($urandom_range(0, 3));
            d.a3 = 5'($urandom_range(0, 3));
            d.rw = 1'($urandom_range(0, 1));
            d.tnew = 2'($urandom_range(0, 2));
            d.sel = 3'($urandom_range(0, 7));
            ur = 2'($urandom_range(0, 3));
            ut = 2'($urandom_range(0, 3));
         end
         fl = ($urandom_range(0, 7) == 0);
         rs = ($urandom_range(0, 63) == 0);
         step(d, ur, ut, fl, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
